alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Registered, handshaked successor to the single-cycle ALU controller. It sits at the ID/EX boundary of the pipelined MIPS datapath. It decodes ALUOp plus funct into a CTRL_W-bit ALU control word and holds the result in a one-entry output stage with valid/ready flow control. Multi-cycle ops (mult/div) stall the stage for MULDIV_LAT cycles before the control word is presented.

Parameters:
CTRL_W, 4, width of aluctrl_o; must be >= 4; codes are zero-extended, except illegal, which is all ones.
ALUOP_W, 3, width of aluop_i; must be >= 3; any code >= 8 is illegal.
MULDIV_LAT, 4, BUSY cycles for mult/div; must be >= 1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  synchronous reset, active-high.
valid_i  input  1  upstream presents an op.
ready_o  output  1  stage can accept this cycle.
aluop_i  input  ALUOP_W  main-control ALU op class.
funct_i  input  6  R-type funct field.
valid_o  output  1  registered control word is valid.
ready_i  input  1  downstream consumes this cycle.
aluctrl_o  output  CTRL_W  ALU control word.
shamt_sel_o  output  1  ALU A operand takes shamt (sll/srl).
multi_o  output  1  current word is a mult/div op.
busy_o  output  1  stage is in multi-cycle wait.
illegal_o  output  1  unsupported aluop/funct combination.

Behaviour:
- Decode for aluop 0 (R-type), funct to code:
  - 0x20/0x21 add → 0010; 0x22/0x23 sub → 0110; 0x24 and → 0000; 0x25 or → 0001.
  - 0x26 xor → 0011; 0x27 nor → 1100; 0x2a slt → 0111; 0x2b sltu → 1000.
  - 0x00 sll → 1001 with shamt_sel; 0x02 srl → 1010 with shamt_sel.
  - 0x18 mult → 1101 with multi; 0x1a div → 1110 with multi.
  - Any other funct → illegal.
- Decode for other aluop values: 1 addi → 0010; 2 lw → 0010; 3 sw → 0010; 4 slti → 0111; 5 beq → 0110; 6 ori → 0001; 7 andi → 0000; >= 8 → illegal.
- Illegal ops: aluctrl_o = all ones, illegal_o = 1, shamt_sel_o = 0, multi_o = 0. They pass through as a normal single-cycle op.
- FSM states are IDLE, BUSY and FULL. Accept condition: valid_i && ready_o.
- IDLE:
  - valid_o = 0, ready_o = 1.
  - On accept: non-multi op → FULL; multi op → BUSY with cnt = MULDIV_LAT-1.
- BUSY:
  - ready_o = 0, valid_o = 0, busy_o = 1.
  - cnt decrements each cycle; cnt == 0 → FULL next cycle.
  - Decoded fields are held stable throughout.
- FULL:
  - valid_o = 1, ready_o = ready_i (combinational pass-through, allowing back-to-back issue).
  - ready_i && valid_i → load the new op (goes to FULL or BUSY as in IDLE).
  - ready_i && !valid_i → IDLE.
  - !ready_i → all outputs held bit-stable.
- Latency from accept edge N:
  - Non-multi: valid_o at N+1.
  - Multi: valid_o at N+MULDIV_LAT+1.
  - Throughput is 1 op/cycle for non-multi ops when ready_i = 1.
- Output fields are registered; only ready_o is combinational.
- Reset (rst_i = 1 at an edge):
  - State → IDLE; valid_o, aluctrl_o, shamt_sel_o, multi_o, busy_o, illegal_o → 0; cnt → 0.
  - ready_o is forced to 0 while rst_i = 1.
  - Reset mid-BUSY or mid-FULL discards the held op; no output is produced for it.
- Inputs are sampled only on accept. Changes on aluop_i/funct_i while not accepted have no effect.

Optional Feature:
- Macro: ALU_CTRL_EXT_EN.
- Defined: full decode table as above, including xor, nor, sltu, sll, srl, mult, div, ori and andi, plus the BUSY state.
- Undefined:
  - Only add/sub/and/or/slt (R-type) and addi/lw/sw/slti/beq decode; everything else is illegal.
  - BUSY state and counter are not synthesised; busy_o, multi_o and shamt_sel_o are tied 0.
  - Latency is always 1.

Test Plan:
- Reset, then valid_i = 1, aluop = 0, funct = 0x22, ready_i = 1 → next cycle valid_o = 1, aluctrl_o = 0110, illegal_o = 0.
- Back-to-back issue of add, or, addi with ready_i = 1 → valid_o held 1; aluctrl_o sequence 0010, 0001, 0010 on consecutive cycles; ready_o = 1 throughout.
- Hold: accept slt, then ready_i = 0 for 3 cycles while valid_i = 1 with funct 0x20 → aluctrl_o stays 0111, ready_o = 0; the new op is accepted in the cycle ready_i returns to 1.
- With EXT_EN and MULDIV_LAT = 4: accept mult at edge N → busy_o = 1 and ready_o = 0 for cycles N+1..N+4; valid_o = 1, aluctrl_o = 1101, multi_o = 1 at N+5.
- Illegal cases: aluop = 0 with funct = 0x3f, and aluop = 8 with ALUOP_W = 4 → aluctrl_o = 1111, illegal_o = 1. Without EXT_EN, funct 0x26 → illegal_o = 1.
- Assert rst_i during BUSY (cycle N+2 of a div) → next cycle valid_o = 0, busy_o = 0, state IDLE; no stale div appears after reset deasserts.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ============================================================================
// Module   : alu_ctrl_seq
// Purpose  : Registered, valid/ready handshaked ALU control decoder for the
//            ID/EX boundary. Macro ALU_CTRL_EXT_EN enables the extended decode
//            table and the multi-cycle BUSY wait for mult/div.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctrl_seq #(
    parameter int CTRL_W     = 4,
    parameter int ALUOP_W    = 3,
    parameter int MULDIV_LAT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [5:0]         funct_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [CTRL_W-1:0]  aluctrl_o,
    output logic               shamt_sel_o,
    output logic               multi_o,
    output logic               busy_o,
    output logic               illegal_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FULL = 2'd2;
`ifdef ALU_CTRL_EXT_EN
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam int         c_CNT_W   = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MULDIV_LAT - 1);
`endif

    logic [1:0]        r_state;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_illegal;

    logic [3:0]        w_code4;
    logic              w_illegal;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_accept;

`ifdef ALU_CTRL_EXT_EN
    logic               r_shamt;
    logic               r_multi;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_shamt;
    logic               w_multi;
`endif

    // ------------------------------------------------------------------
    // Decode: aluop 0 selects the R-type funct table, others map directly
    // ------------------------------------------------------------------
    always_comb begin
        w_code4   = 4'b0000;
        w_illegal = 1'b0;
`ifdef ALU_CTRL_EXT_EN
        w_shamt   = 1'b0;
        w_multi   = 1'b0;
`endif
        if (aluop_i == '0) begin
            case (funct_i)
                6'h20, 6'h21: w_code4 = 4'b0010;
                6'h22, 6'h23: w_code4 = 4'b0110;
                6'h24:        w_code4 = 4'b0000;
                6'h25:        w_code4 = 4'b0001;
                6'h2a:        w_code4 = 4'b0111;
`ifdef ALU_CTRL_EXT_EN
                6'h26:        w_code4 = 4'b0011;
                6'h27:        w_code4 = 4'b1100;
                6'h2b:        w_code4 = 4'b1000;
                6'h00: begin
                    w_code4 = 4'b1001;
                    w_shamt = 1'b1;
                end
                6'h02: begin
                    w_code4 = 4'b1010;
                    w_shamt = 1'b1;
                end
                6'h18: begin
                    w_code4 = 4'b1101;
                    w_multi = 1'b1;
                end
                6'h1a: begin
                    w_code4 = 4'b1110;
                    w_multi = 1'b1;
                end
`endif
                default:      w_illegal = 1'b1;
            endcase
        end else begin
            case (aluop_i)
                ALUOP_W'(1), ALUOP_W'(2), ALUOP_W'(3): w_code4 = 4'b0010;
                ALUOP_W'(4):                           w_code4 = 4'b0111;
                ALUOP_W'(5):                           w_code4 = 4'b0110;
`ifdef ALU_CTRL_EXT_EN
                ALUOP_W'(6):                           w_code4 = 4'b0001;
                ALUOP_W'(7):                           w_code4 = 4'b0000;
`endif
                default:                               w_illegal = 1'b1;
            endcase
        end
    end

    // Illegal ops present all ones regardless of width; legal codes zero-extend
    assign w_ctrl = w_illegal ? {CTRL_W{1'b1}} : CTRL_W'(w_code4);

    // BUSY and reset both refuse new work; FULL passes downstream ready through
    assign ready_o  = !rst_i && ((r_state == c_ST_IDLE) ||
                                 ((r_state == c_ST_FULL) && ready_i));
    assign w_accept = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
`ifdef ALU_CTRL_EXT_EN
            r_shamt   <= 1'b0;
            r_multi   <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
`endif
        end else if (w_accept) begin
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
`ifdef ALU_CTRL_EXT_EN
            r_shamt   <= w_shamt;
            r_multi   <= w_multi;
            if (w_multi) begin
                r_state <= c_ST_BUSY;
                r_cnt   <= c_CNT_LOAD;
                r_valid <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                r_state <= c_ST_FULL;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end
`else
            r_state   <= c_ST_FULL;
            r_valid   <= 1'b1;
`endif
        end else begin
            case (r_state)
`ifdef ALU_CTRL_EXT_EN
                c_ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= c_ST_FULL;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                c_ST_FULL: begin
                    // Fields stay put after drain; only valid drops
                    if (ready_i) begin
                        r_state <= c_ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
`ifdef ALU_CTRL_EXT_EN
                    r_busy  <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign valid_o   = r_valid;
    assign aluctrl_o = r_ctrl;
    assign illegal_o = r_illegal;
`ifdef ALU_CTRL_EXT_EN
    assign shamt_sel_o = r_shamt;
    assign multi_o     = r_multi;
    assign busy_o      = r_busy;
`else
    assign shamt_sel_o = 1'b0;
    assign multi_o     = 1'b0;
    assign busy_o      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// ============================================================================
// Module   : tb_alu_ctrl_seq
// Purpose  : Directed self-checking bench for alu_ctrl_seq (both macro builds).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_seq;

    localparam int CTRL_W     = 4;
    localparam int ALUOP_W    = 4;
    localparam int MULDIV_LAT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic               ready_o;
    logic [ALUOP_W-1:0] aluop_i;
    logic [5:0]         funct_i;
    logic               valid_o;
    logic               ready_i;
    logic [CTRL_W-1:0]  aluctrl_o;
    logic               shamt_sel_o;
    logic               multi_o;
    logic               busy_o;
    logic               illegal_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_seq #(
        .CTRL_W    (CTRL_W),
        .ALUOP_W   (ALUOP_W),
        .MULDIV_LAT(MULDIV_LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .aluop_i    (aluop_i),
        .funct_i    (funct_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .aluctrl_o  (aluctrl_o),
        .shamt_sel_o(shamt_sel_o),
        .multi_o    (multi_o),
        .busy_o     (busy_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ALUOP_W-1:0] op, input logic [5:0] fn);
        valid_i = v;
        aluop_i = op;
        funct_i = fn;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready_i = 1'b1;
        drive(1'b0, '0, 6'h00);
        step(); step();
        n_cmp++;
        if (valid_o !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", valid_o); n_err++; end
        n_cmp++;
        if (aluctrl_o !== 4'b0000) begin $display("FAIL reset_ctrl got=%b want=0000", aluctrl_o); n_err++; end
        n_cmp++;
        if ({illegal_o, busy_o, multi_o, shamt_sel_o} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b want=0000", {illegal_o, busy_o, multi_o, shamt_sel_o}); n_err++;
        end
        n_cmp++;
        if (ready_o !== 1'b0) begin $display("FAIL reset_ready_low got=%b want=0", ready_o); n_err++; end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin $display("FAIL idle_ready got=%b want=1", ready_o); n_err++; end
    endtask

    task automatic test_sub();
        drive(1'b1, 4'd0, 6'h22);
        step();
        drive(1'b0, '0, 6'h00);
        n_cmp++;
        if (valid_o !== 1'b1 || aluctrl_o !== 4'b0110 || illegal_o !== 1'b0) begin
            $display("FAIL sub got=v%b c%b i%b want=v1 c0110 i0", valid_o, aluctrl_o, illegal_o); n_err++;
        end
        step();
        n_cmp++;
        if (valid_o !== 1'b0) begin $display("FAIL sub_drain got=%b want=0", valid_o); n_err++; end
    endtask

    task automatic test_back_to_back();
        logic [ALUOP_W-1:0] ops [3];
        logic [5:0]         fns [3];
        logic [3:0]         exp [3];
        ops = '{4'd0, 4'd0, 4'd1};
        fns = '{6'h20, 6'h25, 6'h00};
        exp = '{4'b0010, 4'b0001, 4'b0010};
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], fns[i]);
            #1;
            n_cmp++;
            if (ready_o !== 1'b1) begin $display("FAIL b2b_ready[%0d] got=%b want=1", i, ready_o); n_err++; end
            step();
            n_cmp++;
            if (valid_o !== 1'b1 || aluctrl_o !== exp[i]) begin
                $display("FAIL b2b_word[%0d] got=v%b c%b want=v1 c%b", i, valid_o, aluctrl_o, exp[i]); n_err++;
            end
        end
        drive(1'b0, '0, 6'h00);
        step();
    endtask

    task automatic test_hold();
        ready_i = 1'b1;
        drive(1'b1, 4'd0, 6'h2a);
        step();
        drive(1'b1, 4'd0, 6'h20);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ready_o !== 1'b0) begin $display("FAIL hold_ready[%0d] got=%b want=0", i, ready_o); n_err++; end
            step();
            n_cmp++;
            if (valid_o !== 1'b1 || aluctrl_o !== 4'b0111) begin
                $display("FAIL hold_word[%0d] got=v%b c%b want=v1 c0111", i, valid_o, aluctrl_o); n_err++;
            end
        end
        ready_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin $display("FAIL hold_release_ready got=%b want=1", ready_o); n_err++; end
        step();
        drive(1'b0, '0, 6'h00);
        n_cmp++;
        if (valid_o !== 1'b1 || aluctrl_o !== 4'b0010) begin
            $display("FAIL hold_next got=v%b c%b want=v1 c0010", valid_o, aluctrl_o); n_err++;
        end
        step();
    endtask

    task automatic test_illegal();
        ready_i = 1'b1;
        drive(1'b1, 4'd0, 6'h3f);
        step();
        drive(1'b1, 4'd8, 6'h20);
        n_cmp++;
        if (aluctrl_o !== 4'b1111 || illegal_o !== 1'b1 || multi_o !== 1'b0 || shamt_sel_o !== 1'b0) begin
            $display("FAIL illegal_funct got=c%b i%b want=c1111 i1", aluctrl_o, illegal_o); n_err++;
        end
        step();
        drive(1'b1, 4'd0, 6'h26);
        n_cmp++;
        if (aluctrl_o !== 4'b1111 || illegal_o !== 1'b1 || valid_o !== 1'b1) begin
            $display("FAIL illegal_aluop8 got=c%b i%b want=c1111 i1", aluctrl_o, illegal_o); n_err++;
        end
        step();
        drive(1'b1, 4'd6, 6'h00);
`ifdef ALU_CTRL_EXT_EN
        n_cmp++;
        if (aluctrl_o !== 4'b0011 || illegal_o !== 1'b0) begin
            $display("FAIL xor got=c%b i%b want=c0011 i0", aluctrl_o, illegal_o); n_err++;
        end
        step();
        drive(1'b0, '0, 6'h00);
        n_cmp++;
        if (aluctrl_o !== 4'b0001 || illegal_o !== 1'b0) begin
            $display("FAIL ori got=c%b i%b want=c0001 i0", aluctrl_o, illegal_o); n_err++;
        end
`else
        n_cmp++;
        if (aluctrl_o !== 4'b1111 || illegal_o !== 1'b1) begin
            $display("FAIL xor_base got=c%b i%b want=c1111 i1", aluctrl_o, illegal_o); n_err++;
        end
        step();
        drive(1'b0, '0, 6'h00);
        n_cmp++;
        if (aluctrl_o !== 4'b1111 || illegal_o !== 1'b1) begin
            $display("FAIL ori_base got=c%b i%b want=c1111 i1", aluctrl_o, illegal_o); n_err++;
        end
`endif
        step();
    endtask

    task automatic test_shift();
        ready_i = 1'b1;
        drive(1'b1, 4'd0, 6'h02);
        step();
        drive(1'b0, '0, 6'h00);
`ifdef ALU_CTRL_EXT_EN
        n_cmp++;
        if (aluctrl_o !== 4'b1010 || shamt_sel_o !== 1'b1 || illegal_o !== 1'b0) begin
            $display("FAIL srl got=c%b s%b want=c1010 s1", aluctrl_o, shamt_sel_o); n_err++;
        end
`else
        n_cmp++;
        if (aluctrl_o !== 4'b1111 || shamt_sel_o !== 1'b0 || illegal_o !== 1'b1) begin
            $display("FAIL srl_base got=c%b s%b want=c1111 s0", aluctrl_o, shamt_sel_o); n_err++;
        end
`endif
        step();
    endtask

    task automatic test_multi();
        ready_i = 1'b1;
        drive(1'b1, 4'd0, 6'h18);
        step();
        drive(1'b0, '0, 6'h00);
`ifdef ALU_CTRL_EXT_EN
        for (int i = 1; i <= MULDIV_LAT; i++) begin
            n_cmp++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
                $display("FAIL mult_busy[N+%0d] got=b%b r%b v%b want=b1 r0 v0", i, busy_o, ready_o, valid_o); n_err++;
            end
            step();
        end
        n_cmp++;
        if (valid_o !== 1'b1 || aluctrl_o !== 4'b1101 || multi_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL mult_done got=v%b c%b m%b b%b want=v1 c1101 m1 b0", valid_o, aluctrl_o, multi_o, busy_o); n_err++;
        end
`else
        n_cmp++;
        if (valid_o !== 1'b1 || aluctrl_o !== 4'b1111 || multi_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL mult_base got=v%b c%b m%b b%b want=v1 c1111 m0 b0", valid_o, aluctrl_o, multi_o, busy_o); n_err++;
        end
`endif
        step();
    endtask

    task automatic test_reset_midop();
        int seen;
        ready_i = 1'b1;
`ifdef ALU_CTRL_EXT_EN
        drive(1'b1, 4'd0, 6'h1a);
        step();
        drive(1'b0, '0, 6'h00);
        step();
`else
        ready_i = 1'b0;
        drive(1'b1, 4'd0, 6'h24);
        step();
        drive(1'b0, '0, 6'h00);
        step();
        ready_i = 1'b1;
`endif
        rst = 1'b1;
        step();
        n_cmp++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b0) begin
            $display("FAIL rst_midop got=v%b b%b r%b want=v0 b0 r0", valid_o, busy_o, ready_o); n_err++;
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 6'h20);
        seen = 0;
        for (int i = 0; i < MULDIV_LAT + 3; i++) begin
            step();
            if (valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin $display("FAIL rst_stale got=%0d cycles want=0", seen); n_err++; end
        n_cmp++;
        if (aluctrl_o !== 4'b0000 || ready_o !== 1'b1) begin
            $display("FAIL no_sample got=c%b r%b want=c0000 r1", aluctrl_o, ready_o); n_err++;
        end
    endtask

    initial begin
        rst = 1'b1; ready_i = 1'b0;
        valid_i = 1'b0; aluop_i = '0; funct_i = '0;
        test_reset();
        test_sub();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_shift();
        test_multi();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
